// File: rtl/kmap_lut_engine_if.sv
// Handshake and data bundle for kmap_lut_engine: serial table load, live lookup,
// and truth-table sweep. Signal suffixes are from the engine's point of view.
interface kmap_lut_engine_if #(
  parameter int N_IN = 4
);
  logic            load_start_i;
  logic            cfg_valid_i;
  logic            cfg_ready_o;
  logic            cfg_bit_i;
  logic [N_IN-1:0] in_vec_i;
  logic            out_o;
  logic            sweep_start_i;
  logic            sweep_valid_o;
  logic [N_IN-1:0] sweep_idx_o;
  logic            sweep_out_o;
  logic            sweep_done_o;
  logic [N_IN:0]   ones_count_o;
  logic            busy_o;

  modport slave (
    input  load_start_i, cfg_valid_i, cfg_bit_i, in_vec_i, sweep_start_i,
    output cfg_ready_o, out_o, sweep_valid_o, sweep_idx_o, sweep_out_o,
           sweep_done_o, ones_count_o, busy_o
  );

  modport master (
    output load_start_i, cfg_valid_i, cfg_bit_i, in_vec_i, sweep_start_i,
    input  cfg_ready_o, out_o, sweep_valid_o, sweep_idx_o, sweep_out_o,
           sweep_done_o, ones_count_o, busy_o
  );
endinterface

// File: rtl/kmap_lut_engine.sv
// Programmable N_IN-input Boolean function held in a serially loaded truth table,
// with a registered lookup and a built-in sweep that counts the 1 minterms.
module kmap_lut_engine #(
  parameter int N_IN = 4
) (
  input  logic                clk,
  input  logic                rst,
  kmap_lut_engine_if.slave    bus
);
  localparam int              DEPTH    = 2 ** N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] IDX_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [DEPTH-1:0] table_q;
  logic [N_IN-1:0] load_ptr_q;
  logic [N_IN-1:0] idx_q;
  logic [N_IN:0]   acc_q;
  logic [N_IN:0]   ones_count_q;
  logic            out_q;

  logic            cfg_ready;
  logic            sweep_valid;
  logic            sweep_out;
  logic [N_IN-1:0] sweep_idx;
  logic            sweep_done;
  logic            busy;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d defaults to state_q before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load_start_i)       state_d = S_LOAD;
        else if (bus.sweep_start_i) state_d = S_SWEEP;
      end
      S_LOAD:  if (bus.cfg_valid_i && load_ptr_q == LAST_IDX) state_d = S_IDLE;
      S_SWEEP: if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready   = (state_q == S_LOAD);
    sweep_valid = (state_q == S_SWEEP);
    sweep_done  = (state_q == S_DONE);
    busy        = (state_q == S_LOAD) || (state_q == S_SWEEP);
    sweep_idx   = sweep_valid ? idx_q : '0;
    sweep_out   = sweep_valid & table_q[idx_q];
  end

  // NOTE: the truth table is flops, not RAM, so it is cleared by reset like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      table_q      <= '0;
      load_ptr_q   <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      ones_count_q <= '0;
      out_q        <= 1'b0;
    end else begin
      out_q <= table_q[bus.in_vec_i];
      case (state_q)
        // Pointers and accumulator are parked at zero so every LOAD/SWEEP starts clean.
        S_IDLE: begin
          load_ptr_q <= '0;
          idx_q      <= '0;
          acc_q      <= '0;
        end
        S_LOAD: begin
          if (bus.cfg_valid_i) begin
            table_q[load_ptr_q] <= bus.cfg_bit_i;
            load_ptr_q          <= load_ptr_q + IDX_ONE;
          end
        end
        S_SWEEP: begin
          acc_q <= acc_q + {{N_IN{1'b0}}, sweep_out};
          idx_q <= idx_q + IDX_ONE;
        end
        S_DONE:  ones_count_q <= acc_q;
        default: ;
      endcase
    end
  end

  assign bus.cfg_ready_o   = cfg_ready;
  assign bus.out_o         = out_q;
  assign bus.sweep_valid_o = sweep_valid;
  assign bus.sweep_idx_o   = sweep_idx;
  assign bus.sweep_out_o   = sweep_out;
  assign bus.sweep_done_o  = sweep_done;
  assign bus.ones_count_o  = ones_count_q;
  assign bus.busy_o        = busy;
endmodule

// File: tb/tb_kmap_lut_engine.sv
// Self-checking bench for kmap_lut_engine: directed scenarios plus randomized tables,
// stall patterns and lookups, compared against a bit-vector truth-table model.
module tb_kmap_lut_engine;
  localparam int N     = 4;
  localparam int DEPTH = 2 ** N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kmap_lut_engine_if #(.N_IN(N)) bus ();
  kmap_lut_engine #(.N_IN(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [DEPTH-1:0] ref_tbl;
  int               ref_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lookup check: ordered walks all minterms, otherwise n random in_vec values.
  task automatic eval_check(input bit ordered, input int n);
    int v;
    for (int k = 0; k < n; k++) begin
      v = ordered ? (k % DEPTH) : int'($urandom_range(0, DEPTH - 1));
      bus.in_vec_i = v[N-1:0];
      tick();
      check("eval_out", bus.out_o, ref_tbl[v]);
    end
  endtask

  // stall_pct < 0 selects strict alternation (valid low, high, low, ...).
  task automatic do_load(input logic [DEPTH-1:0] val, input int stall_pct, input bit conflict,
                         output int cycles);
    logic [DEPTH-1:0] old;
    bit               valid;
    int               i;
    old    = ref_tbl;
    i      = 0;
    cycles = 0;
    bus.load_start_i  = 1'b1;
    bus.sweep_start_i = conflict;
    tick();
    bus.load_start_i  = 1'b0;
    bus.sweep_start_i = 1'b0;
    check("load_entry_ready", bus.cfg_ready_o, 1);
    check("load_entry_busy", bus.busy_o, 1);
    check("load_entry_nosweep", bus.sweep_valid_o, 0);
    while (i < DEPTH && cycles < 400) begin
      valid = (stall_pct < 0) ? (cycles % 2 == 1) : ($urandom_range(0, 99) >= stall_pct);
      bus.cfg_valid_i   = valid;
      bus.cfg_bit_i     = val[i];
      bus.in_vec_i      = i[N-1:0];
      bus.sweep_start_i = conflict & 1'($urandom_range(0, 1));
      bus.load_start_i  = conflict & 1'($urandom_range(0, 1));
      tick();
      check("load_old_entry", bus.out_o, old[i]);
      if (valid) i++;
      cycles++;
      if (i < DEPTH) begin
        check("load_ready_held", bus.cfg_ready_o, 1);
        check("load_no_sweep", bus.sweep_valid_o, 0);
      end
    end
    bus.cfg_valid_i   = 1'b0;
    bus.sweep_start_i = 1'b0;
    bus.load_start_i  = 1'b0;
    if (i < DEPTH) check("load_timeout", i, DEPTH);
    check("load_exit_ready", bus.cfg_ready_o, 0);
    check("load_exit_busy", bus.busy_o, 0);
    ref_tbl = val;
  endtask

  // abort_at >= 0 stops after checking that beat, leaving the engine mid-sweep.
  task automatic do_sweep(input int abort_at);
    bus.sweep_start_i = 1'b1;
    tick();
    bus.sweep_start_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      check("sweep_valid", bus.sweep_valid_o, 1);
      check("sweep_idx", bus.sweep_idx_o, k);
      check("sweep_out", bus.sweep_out_o, ref_tbl[k]);
      if (k == abort_at) return;
      check("sweep_busy", bus.busy_o, 1);
      check("sweep_no_done", bus.sweep_done_o, 0);
      tick();
    end
    check("done_pulse", bus.sweep_done_o, 1);
    check("done_valid_low", bus.sweep_valid_o, 0);
    check("done_busy_low", bus.busy_o, 0);
    tick();
    ref_count = $countones(ref_tbl);
    check("done_single", bus.sweep_done_o, 0);
    check("ones_count", bus.ones_count_o, ref_count);
    check("idle_busy", bus.busy_o, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  cyc;
    bit  saw_done;
    logic [DEPTH-1:0] rnd;
    int  prev_count;

    rst = 1'b1;
    bus.load_start_i  = 1'b0;
    bus.cfg_valid_i   = 1'b0;
    bus.cfg_bit_i     = 1'b0;
    bus.in_vec_i      = '0;
    bus.sweep_start_i = 1'b0;
    ref_tbl   = '0;
    ref_count = 0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_out", bus.out_o, 0);
    check("rst_ones", bus.ones_count_o, 0);
    check("rst_ready", bus.cfg_ready_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_sweep_valid", bus.sweep_valid_o, 0);
    check("rst_sweep_done", bus.sweep_done_o, 0);
    eval_check(1'b1, DEPTH);

    // Gapless load of 16'hA5C3, ordered lookup, sweep
    do_load(16'hA5C3, 0, 1'b0, cyc);
    check("load_cycles_gapless", cyc, DEPTH);
    eval_check(1'b1, DEPTH);
    do_sweep(-1);
    check("count_a5c3", bus.ones_count_o, 8);

    // Alternating-stall load over a cleared table
    do_load('0, 0, 1'b0, cyc);
    do_load(16'hA5C3, -1, 1'b0, cyc);
    check("load_cycles_stalled", cyc, 2 * DEPTH);
    do_sweep(-1);
    check("count_a5c3_stalled", bus.ones_count_o, 8);

    // Conflicting start pulses: load wins, sweep_start ignored during load
    prev_count = ref_count;
    rnd = DEPTH'($urandom);
    do_load(rnd, 30, 1'b1, cyc);
    check("conflict_no_sweep", bus.sweep_valid_o, 0);
    check("conflict_count_kept", bus.ones_count_o, prev_count);
    eval_check(1'b0, 12);
    do_sweep(-1);

    // All-ones table reports full depth without wrap
    do_load('1, 0, 1'b0, cyc);
    do_sweep(-1);
    check("count_all_ones", bus.ones_count_o, 5'b10000);

    // Reset at sweep beat 5 aborts everything
    do_sweep(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_tbl   = '0;
    ref_count = 0;
    check("abort_valid", bus.sweep_valid_o, 0);
    check("abort_ones", bus.ones_count_o, 0);
    check("abort_busy", bus.busy_o, 0);
    saw_done = 1'b0;
    for (int k = 0; k < DEPTH + 4; k++) begin
      if (bus.sweep_done_o === 1'b1) saw_done = 1'b1;
      tick();
    end
    check("abort_no_done", saw_done, 0);
    eval_check(1'b1, DEPTH);

    // Randomized tables, stall rates and lookups
    for (int it = 0; it < 6; it++) begin
      rnd = DEPTH'($urandom);
      do_load(rnd, int'($urandom_range(0, 60)), 1'b0, cyc);
      eval_check(1'b0, 20);
      do_sweep(-1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
